pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage RV32 core.
//  - Detects load-use hazards between the load in ID/EX and the instruction in IF/ID.
//  - Flushes wrong-path instructions on a taken branch or jump.
//  - Freezes the pipe while a multi-cycle data-memory access is outstanding.
//  - Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.
// PARAMETERS
//  RF_ADDRESS_W  5    register-file address width
//  FLUSH_CYC     1    cycles of flush per taken branch (1..4)
//  WAIT_MAX      255  max MEM_WAIT cycles before mem_timeout is set
//  CNT_W         16   performance counter width
// PORTS
//  clk             in   1      clock, rising edge
//  reset           in   1      synchronous, active-high
//  MemtoReg_IDEX   in   1      instruction in ID/EX is a load
//  RD_IDEX         in   RF_ADDRESS_W  destination register in ID/EX
//  RS1_IFID        in   RF_ADDRESS_W  rs1 of instruction in IF/ID
//  RS2_IFID        in   RF_ADDRESS_W  rs2 of instruction in IF/ID
//  branch_taken    in   1      EX resolves a taken branch/jump this cycle
//  mem_req         in   1      MEM stage issues a data access this cycle
//  mem_ready       in   1      data memory completes the access this cycle
//  PCWrite         out  1      PC update enable
//  IFIDWrite       out  1      IF/ID load enable
//  IDEXWrite       out  1      ID/EX load enable
//  EXMEMWrite      out  1      EX/MEM load enable
//  IFID_Flush      out  1      load NOP into IF/ID
//  IDEX_Flush      out  1      zero ID/EX control fields (bubble)
//  mem_timeout     out  1      sticky: access exceeded WAIT_MAX cycles
//  stall_cnt       out  CNT_W  saturating count of stall cycles
//  flush_cnt       out  CNT_W  saturating count of branch flush events
// BEHAVIOUR
//  - Enables and flushes are combinational from state and inputs. Counters, flag and state are registered.
//  - Reset is synchronous and active-high. It overrides all else, including mid-wait.
//    On reset: state=RUN, fcnt=0, wcnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
//    During reset: all *Write=1, all *Flush=0.
//  - Default outputs: all *Write=1, all *Flush=0.
//  - lu_haz = MemtoReg_IDEX && RD_IDEX!=0 && (RD_IDEX==RS1_IFID || RD_IDEX==RS2_IFID).
//  - Priority in every state: memory wait > branch > load-use.
//  - RUN:
//    - mem_req && !mem_ready: all four *Write=0 and nothing flushes. Next state is MEM_WAIT, wcnt<=1.
//    - else branch_taken: IFID_Flush=1, IDEX_Flush=1, PCWrite=1, flush_cnt++.
//      If FLUSH_CYC>1, next state is BR_FLUSH with fcnt<=FLUSH_CYC-1.
//    - else lu_haz: PCWrite=0, IFIDWrite=0, IDEX_Flush=1, stall_cnt++. State stays RUN.
//      The bubble clears the hazard, so the stall lasts exactly 1 cycle.
//  - MEM_WAIT:
//    - Every cycle: all *Write=0, stall_cnt++, wcnt++ (saturates at WAIT_MAX).
//    - wcnt==WAIT_MAX sets mem_timeout. It stays set until reset; the freeze continues.
//    - branch_taken and lu_haz are ignored here. The branch is still held in EX and is re-seen in RUN.
//    - mem_ready: this is the last frozen cycle. Next state is RUN, wcnt<=0.
//  - BR_FLUSH:
//    - Every cycle: IFID_Flush=1, IDEX_Flush=1, fcnt--. Go to RUN when fcnt==1.
//    - mem_req && !mem_ready has priority: go to MEM_WAIT and discard the remaining flush cycles.
//    - A new branch_taken reloads fcnt<=FLUSH_CYC-1 and increments flush_cnt.
//  - A 1-cycle access (mem_req && mem_ready in RUN) never stalls.
//  - Counters saturate at 2^CNT_W-1 and never wrap.
//  - FLUSH_CYC is restricted to 1..4. An out-of-range value is an elaboration error via $error.
// TESTING
//  - Load-use: MemtoReg_IDEX=1, RD_IDEX=5, RS2_IFID=5 -> exactly 1 cycle of PCWrite=IFIDWrite=0, IDEX_Flush=1; stall_cnt=1.
//  - x0: MemtoReg_IDEX=1, RD_IDEX=0, RS1_IFID=0 -> no stall; stall_cnt=0.
//  - Branch, FLUSH_CYC=2: branch_taken pulse -> IFID_Flush/IDEX_Flush high 2 cycles; flush_cnt=1.
//  - Mem wait: mem_req=1, mem_ready low 3 cycles then high -> all *Write=0 for 4 cycles; then RUN; stall_cnt=4.
//  - Timeout, WAIT_MAX=8: mem_ready held low 20 cycles -> mem_timeout=1 after 8 cycles and stays set.
//    A reset asserted mid-wait -> next cycle state=RUN, all outputs at reset values.
//  - Simultaneous: branch_taken + lu_haz + mem_req&&!mem_ready -> freeze only, no flush.
//    After mem_ready, the held branch flushes.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Sequences the IF/ID, ID/EX and EX/MEM pipeline registers of the 5-stage
//   RV32 core. It stalls one cycle on a load-use hazard, flushes wrong-path
//   instructions after a taken branch or jump, and freezes the whole pipe
//   while a multi-cycle data-memory access is outstanding. It also keeps
//   saturating stall/flush performance counters and a sticky memory-timeout
//   flag.
//
// Parameters:
//   RF_ADDRESS_W  register-file address width
//   FLUSH_CYC     flush cycles per taken branch, 1..4
//   WAIT_MAX      memory-wait cycles before mem_timeout is raised
//   CNT_W         performance counter width
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   MemtoReg_IDEX  in   instruction in ID/EX is a load
//   RD_IDEX        in   destination register of the ID/EX instruction
//   RS1_IFID       in   rs1 of the IF/ID instruction
//   RS2_IFID       in   rs2 of the IF/ID instruction
//   branch_taken   in   EX resolves a taken branch/jump this cycle
//   mem_req        in   MEM stage issues a data access this cycle
//   mem_ready      in   data memory completes the access this cycle
//   PCWrite        out  PC update enable
//   IFIDWrite      out  IF/ID load enable
//   IDEXWrite      out  ID/EX load enable
//   EXMEMWrite     out  EX/MEM load enable
//   IFID_Flush     out  load a NOP into IF/ID
//   IDEX_Flush     out  zero the ID/EX control fields (bubble)
//   mem_timeout    out  sticky: an access exceeded WAIT_MAX cycles
//   stall_cnt      out  saturating count of stall cycles
//   flush_cnt      out  saturating count of branch flush events
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RF_ADDRESS_W = 5,
  parameter int FLUSH_CYC    = 1,
  parameter int WAIT_MAX     = 255,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemtoReg_IDEX,
  input  logic [RF_ADDRESS_W-1:0] RD_IDEX,
  input  logic [RF_ADDRESS_W-1:0] RS1_IFID,
  input  logic [RF_ADDRESS_W-1:0] RS2_IFID,
  input  logic                    branch_taken,
  input  logic                    mem_req,
  input  logic                    mem_ready,
  output logic                    PCWrite,
  output logic                    IFIDWrite,
  output logic                    IDEXWrite,
  output logic                    EXMEMWrite,
  output logic                    IFID_Flush,
  output logic                    IDEX_Flush,
  output logic                    mem_timeout,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  localparam int WCNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [WCNT_W-1:0] WAIT_MAX_V   = WCNT_W'(WAIT_MAX);
  localparam logic [WCNT_W-1:0] WCNT_ONE     = WCNT_W'(1);
  localparam logic [1:0]        FLUSH_RELOAD = 2'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

  // The flush counter is only two bits wide, so the parameter range is
  // enforced at elaboration.
  if (FLUSH_CYC < 1 || FLUSH_CYC > 4) begin : g_bad_flush_cyc
    $error("pipe_hazard_ctrl: FLUSH_CYC must be in 1..4, got %0d", FLUSH_CYC);
  end

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_BR_FLUSH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         fcnt_q, fcnt_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic lu_haz;
  logic mem_stall;
  logic stall_inc;
  logic flush_inc;

  // A load into x0 never creates a real dependency, so it is excluded.
  assign lu_haz = MemtoReg_IDEX && (RD_IDEX != '0) &&
                  ((RD_IDEX == RS1_IFID) || (RD_IDEX == RS2_IFID));

  assign mem_stall = mem_req && !mem_ready;

  // Next-state and output logic. Memory wait has priority over branch,
  // which has priority over load-use. While reset is high the outputs stay
  // at their free-running defaults; the register block clears the state.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    wcnt_d        = wcnt_q;
    mem_timeout_d = mem_timeout_q;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    PCWrite       = 1'b1;
    IFIDWrite     = 1'b1;
    IDEXWrite     = 1'b1;
    EXMEMWrite    = 1'b1;
    IFID_Flush    = 1'b0;
    IDEX_Flush    = 1'b0;

    if (!reset) begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_stall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            stall_inc  = 1'b1;
            wcnt_d     = WCNT_ONE;
            state_d    = ST_MEM_WAIT;
          end else if (branch_taken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_CYC > 1) begin
              fcnt_d  = FLUSH_RELOAD;
              state_d = ST_BR_FLUSH;
            end
          end else if (lu_haz) begin
            // The bubble removes the load from ID/EX, so one cycle suffices.
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEX_Flush = 1'b1;
            stall_inc  = 1'b1;
          end
        end

        ST_MEM_WAIT: begin
          // Branch and load-use are ignored here; the branch is still held
          // in EX and is seen again once the pipe returns to RUN.
          PCWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          IDEXWrite  = 1'b0;
          EXMEMWrite = 1'b0;
          stall_inc  = 1'b1;
          if (wcnt_q != WAIT_MAX_V) begin
            wcnt_d = wcnt_q + WCNT_ONE;
          end
          if (wcnt_q == WAIT_MAX_V) begin
            mem_timeout_d = 1'b1;
          end
          if (mem_ready) begin
            wcnt_d  = '0;
            state_d = ST_RUN;
          end
        end

        ST_BR_FLUSH: begin
          if (mem_stall) begin
            // Remaining flush cycles are abandoned in favour of the freeze.
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMWrite = 1'b0;
            stall_inc  = 1'b1;
            wcnt_d     = WCNT_ONE;
            fcnt_d     = '0;
            state_d    = ST_MEM_WAIT;
          end else begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
            if (branch_taken) begin
              flush_inc = 1'b1;
              fcnt_d    = FLUSH_RELOAD;
            end else if (fcnt_q <= 2'd1) begin
              fcnt_d  = '0;
              state_d = ST_RUN;
            end else begin
              fcnt_d = fcnt_q - 2'd1;
            end
          end
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, counters and the sticky flag; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      fcnt_q        <= '0;
      wcnt_q        <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      wcnt_q        <= wcnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Purpose:
//   Self-checking bench for pipe_hazard_ctrl with FLUSH_CYC=2, WAIT_MAX=8 and
//   a 3-bit counter width so that counter saturation is reachable quickly.
//   Each cycle's stimulus is driven together with its expected outputs;
//   expected records are queued and compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RF_W = 5;
  localparam int CNT_W = 3;

  // Control output bundle order: PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
  // IFID_Flush, IDEX_Flush.
  localparam logic [5:0] NRM = 6'b111100;
  localparam logic [5:0] FRZ = 6'b000000;
  localparam logic [5:0] LU  = 6'b001101;
  localparam logic [5:0] FL  = 6'b111111;

  typedef struct {
    logic             rst;
    logic             mtr;
    logic [RF_W-1:0]  rd;
    logic [RF_W-1:0]  rs1;
    logic [RF_W-1:0]  rs2;
    logic             br;
    logic             req;
    logic             rdy;
    logic [5:0]       ctrl;
    logic             to;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] fl;
    logic             chk_to;
    logic             chk_cnt;
    string            name;
    int               idx;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             MemtoReg_IDEX;
  logic [RF_W-1:0]  RD_IDEX, RS1_IFID, RS2_IFID;
  logic             branch_taken, mem_req, mem_ready;
  logic             PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite;
  logic             IFID_Flush, IDEX_Flush, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  vec_t exp_q[$];
  vec_t tbl[40];

  pipe_hazard_ctrl #(
    .RF_ADDRESS_W(RF_W),
    .FLUSH_CYC(2),
    .WAIT_MAX(8),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .MemtoReg_IDEX(MemtoReg_IDEX),
    .RD_IDEX(RD_IDEX),
    .RS1_IFID(RS1_IFID),
    .RS2_IFID(RS2_IFID),
    .branch_taken(branch_taken),
    .mem_req(mem_req),
    .mem_ready(mem_ready),
    .PCWrite(PCWrite),
    .IFIDWrite(IFIDWrite),
    .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite),
    .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic mtr,
                              input logic [RF_W-1:0] rd, input logic [RF_W-1:0] rs1,
                              input logic [RF_W-1:0] rs2, input logic br,
                              input logic req, input logic rdy,
                              input logic [5:0] ctrl, input logic to,
                              input logic [CNT_W-1:0] st, input logic [CNT_W-1:0] fl);
    vec_t v;
    v.rst = rst; v.mtr = mtr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.br = br; v.req = req; v.rdy = rdy;
    v.ctrl = ctrl; v.to = to; v.st = st; v.fl = fl;
    v.chk_to = 1'b1; v.chk_cnt = 1'b1;
    v.name = "tbl"; v.idx = 0;
    return v;
  endfunction

  // Drives one cycle of inputs and queues what the DUT must show for it.
  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    MemtoReg_IDEX = v.mtr;
    RD_IDEX       = v.rd;
    RS1_IFID      = v.rs1;
    RS2_IFID      = v.rs2;
    branch_taken  = v.br;
    mem_req       = v.req;
    mem_ready     = v.rdy;
    exp_q.push_back(v);
  endtask

  // Pops the oldest expectation and compares it against the DUT outputs.
  task automatic checkOutput();
    vec_t e;
    logic [5:0] act;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue, required one record");
      return;
    end
    e = exp_q.pop_front();
    act = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFID_Flush, IDEX_Flush};
    if (act !== e.ctrl) begin
      failures++;
      $display("[TB] FAIL %s[%0d] ctrl: got %b required %b", e.name, e.idx, act, e.ctrl);
    end
    if (e.chk_to) begin
      checks++;
      if (mem_timeout !== e.to) begin
        failures++;
        $display("[TB] FAIL %s[%0d] mem_timeout: got %b required %b", e.name, e.idx, mem_timeout, e.to);
      end
    end
    if (e.chk_cnt) begin
      checks++;
      if (stall_cnt !== e.st) begin
        failures++;
        $display("[TB] FAIL %s[%0d] stall_cnt: got %0d required %0d", e.name, e.idx, stall_cnt, e.st);
      end
      checks++;
      if (flush_cnt !== e.fl) begin
        failures++;
        $display("[TB] FAIL %s[%0d] flush_cnt: got %0d required %0d", e.name, e.idx, flush_cnt, e.fl);
      end
    end
  endtask

  task automatic runVec(input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    vec_t v;

    //              rst mtr rd     rs1    rs2    br req rdy ctrl to st fl
    tbl[0]  = mk(1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 0, NRM, 0, 0, 0); // reset beats all
    tbl[1]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 0, 0);
    tbl[2]  = mk(0, 1, 5'd5, 5'd3, 5'd5, 0, 0, 0, LU,  0, 0, 0); // rs2 load-use
    tbl[3]  = mk(0, 0, 5'd0, 5'd5, 5'd5, 0, 0, 0, NRM, 0, 1, 0);
    tbl[4]  = mk(0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, LU,  0, 1, 0); // rs1 load-use
    tbl[5]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 2, 0);
    tbl[6]  = mk(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 2, 0); // x0 load
    tbl[7]  = mk(0, 0, 5'd5, 5'd5, 5'd0, 0, 0, 0, NRM, 0, 2, 0); // not a load
    tbl[8]  = mk(0, 1, 5'd6, 5'd5, 5'd7, 0, 0, 0, NRM, 0, 2, 0); // no match
    tbl[9]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, FL,  0, 2, 0); // branch
    tbl[10] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FL,  0, 2, 1);
    tbl[11] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 2, 1);
    tbl[12] = mk(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, FL,  0, 2, 1); // branch beats lu
    tbl[13] = mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, FL,  0, 2, 2); // lu ignored in flush
    tbl[14] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 2, 2);
    tbl[15] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, FL,  0, 2, 2);
    tbl[16] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, FL,  0, 2, 3); // reload in flush
    tbl[17] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FL,  0, 2, 4);
    tbl[18] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 2, 4);
    tbl[19] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, NRM, 0, 2, 4); // 1-cycle access
    tbl[20] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 2, 4);
    tbl[21] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, FRZ, 0, 2, 4); // mem wait
    tbl[22] = mk(0, 1, 5'd5, 5'd5, 5'd0, 1, 1, 0, FRZ, 0, 3, 4); // br/lu ignored
    tbl[23] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, FRZ, 0, 4, 4);
    tbl[24] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, FRZ, 0, 5, 4); // last frozen
    tbl[25] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 6, 4);
    tbl[26] = mk(0, 1, 5'd5, 5'd5, 5'd0, 1, 1, 0, FRZ, 0, 6, 4); // all three
    tbl[27] = mk(0, 1, 5'd5, 5'd5, 5'd0, 1, 1, 1, FRZ, 0, 7, 4);
    tbl[28] = mk(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, FL,  0, 7, 4); // held branch
    tbl[29] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FL,  0, 7, 5);
    tbl[30] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 7, 5);
    tbl[31] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, FL,  0, 7, 5);
    tbl[32] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, FRZ, 0, 7, 6); // mem beats flush
    tbl[33] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, FRZ, 0, 7, 6);
    tbl[34] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 7, 6);
    tbl[35] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, FL,  0, 7, 6);
    tbl[36] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, FL,  0, 7, 7);
    tbl[37] = mk(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, FL,  0, 7, 7); // flush_cnt saturated
    tbl[38] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, FL,  0, 7, 7);
    tbl[39] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 7, 7);

    reset = 1'b1;
    MemtoReg_IDEX = 1'b0;
    RD_IDEX = '0;
    RS1_IFID = '0;
    RS2_IFID = '0;
    branch_taken = 1'b0;
    mem_req = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      v = tbl[i];
      v.idx = i;
      runVec(v);
    end

    // Fresh start for the long wait: counters cleared.
    v = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 0, 0);
    v.name = "rst";
    v.chk_cnt = 1'b0;
    v.chk_to = 1'b0;
    runVec(v);
    v.chk_cnt = 1'b1;
    v.chk_to = 1'b1;
    v.idx = 1;
    runVec(v);

    // Memory never answers for 20 cycles; the flag rises around cycle 8.
    for (int i = 0; i < 20; i++) begin
      v = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, FRZ, (i >= 9) ? 1'b1 : 1'b0,
             (i < 7) ? CNT_W'(i) : 3'd7, 0);
      v.chk_to = (i <= 7) || (i >= 9);
      v.name = "tmo";
      v.idx = i;
      runVec(v);
    end

    // Access finally completes; the flag stays sticky afterwards.
    v = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, FRZ, 1, 7, 0); v.name = "tmo"; v.idx = 20; runVec(v);
    v = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 1, 7, 0); v.name = "tmo"; v.idx = 21; runVec(v);
    v = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, FRZ, 1, 7, 0); v.name = "tmo"; v.idx = 22; runVec(v);
    v = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, FRZ, 1, 7, 0); v.name = "tmo"; v.idx = 23; runVec(v);
    // Reset lands in the middle of a wait.
    v = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, NRM, 1, 7, 0); v.name = "tmo"; v.idx = 24; runVec(v);
    v = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, NRM, 0, 0, 0); v.name = "tmo"; v.idx = 25; runVec(v);
    v = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, NRM, 0, 0, 0); v.name = "tmo"; v.idx = 26; runVec(v);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d records left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
